// File: rtl/victim_refill_ctrl.sv
// Dcache-side refill controller for the 4-entry victim cache.
// It probes the victim cache, falls back to memory, writes back the evicted line and returns the refill line.
module victim_refill_ctrl #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 28,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              miss_req_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              evict_valid_i,
  input  logic [ADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0] evict_data_i,
  output logic [ADDR_W-1:0] victim_addr_o,
  output logic [LINE_W-1:0] victim_data_o,
  output logic              victim_write_o,
  output logic              victim_flush_o,
  input  logic              victim_hit_i,
  input  logic [LINE_W-1:0] victim_data_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              resp_valid_o,
  output logic [LINE_W-1:0] resp_data_o,
  output logic              resp_from_victim_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM,
    WRVIC,
    RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] miss_addr_q;
  logic              evict_valid_q;
  logic [ADDR_W-1:0] evict_addr_q;
  logic [LINE_W-1:0] evict_data_q;
  logic [LINE_W-1:0] refill_q;
  logic              from_victim_q;
  logic              flush_pend_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and ordering inside the block cannot create races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      miss_addr_q        <= '0;
      evict_valid_q      <= 1'b0;
      evict_addr_q       <= '0;
      evict_data_q       <= '0;
      refill_q           <= '0;
      from_victim_q      <= 1'b0;
      flush_pend_q       <= 1'b0;
      victim_addr_o      <= '0;
      victim_data_o      <= '0;
      victim_write_o     <= 1'b0;
      victim_flush_o     <= 1'b0;
      mem_req_o          <= 1'b0;
      mem_addr_o         <= '0;
      resp_valid_o       <= 1'b0;
      resp_data_o        <= '0;
      resp_from_victim_o <= 1'b0;
      hit_cnt_o          <= '0;
      miss_cnt_o         <= '0;
    end else begin
      // Pulse-type outputs default low; the shared victim port idles at zero.
      victim_write_o <= 1'b0;
      victim_flush_o <= 1'b0;
      resp_valid_o   <= 1'b0;
      victim_addr_o  <= '0;
      victim_data_o  <= '0;

      if (flush_i && state != IDLE) flush_pend_q <= 1'b1;

      case (state)
        IDLE: begin
          if (flush_i || flush_pend_q) begin
            victim_flush_o <= 1'b1;
            hit_cnt_o      <= '0;
            miss_cnt_o     <= '0;
            flush_pend_q   <= 1'b0;
          end else if (miss_req_i) begin
            miss_addr_q   <= miss_addr_i;
            evict_valid_q <= evict_valid_i;
            evict_addr_q  <= evict_addr_i;
            evict_data_q  <= evict_data_i;
            victim_addr_o <= miss_addr_i;
            state         <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (victim_hit_i) begin
            refill_q      <= victim_data_i;
            from_victim_q <= 1'b1;
            if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_W'(1);
            if (evict_valid_q) begin
              victim_write_o <= 1'b1;
              victim_addr_o  <= evict_addr_q;
              victim_data_o  <= evict_data_q;
              state          <= WRVIC;
            end else begin
              resp_valid_o       <= 1'b1;
              resp_data_o        <= victim_data_i;
              resp_from_victim_o <= 1'b1;
              state              <= RESP;
            end
          end else begin
            if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
            mem_req_o  <= 1'b1;
            mem_addr_o <= miss_addr_q;
            state      <= MEM;
          end
        end

        MEM: begin
          if (mem_ack_i) begin
            refill_q      <= mem_data_i;
            from_victim_q <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            if (evict_valid_q) begin
              victim_write_o <= 1'b1;
              victim_addr_o  <= evict_addr_q;
              victim_data_o  <= evict_data_q;
              state          <= WRVIC;
            end else begin
              resp_valid_o       <= 1'b1;
              resp_data_o        <= mem_data_i;
              resp_from_victim_o <= 1'b0;
              state              <= RESP;
            end
          end
        end

        // The write may replace the entry just hit; its data already sits in refill_q.
        WRVIC: begin
          resp_valid_o       <= 1'b1;
          resp_data_o        <= refill_q;
          resp_from_victim_o <= from_victim_q;
          state              <= RESP;
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_refill_ctrl.sv
// Directed bench for victim_refill_ctrl with a 4-entry FIFO victim cache model and a scripted memory.
// A second instance with CNT_W = 2 exercises counter saturation.
module tb_victim_refill_ctrl;
  localparam int LW = 128;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_in = 1'b0;
  logic          miss_req = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          evict_valid = 1'b0;
  logic [AW-1:0] evict_addr = '0;
  logic [LW-1:0] evict_data = '0;
  logic [AW-1:0] victim_addr;
  logic [LW-1:0] victim_wdata;
  logic          victim_write;
  logic          victim_flush;
  logic          vc_hit;
  logic [LW-1:0] vc_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [LW-1:0] mem_data = '0;
  logic          resp_valid;
  logic [LW-1:0] resp_data;
  logic          resp_fv;
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;

  // Saturation instance
  logic          s_miss_req = 1'b0;
  logic [AW-1:0] s_victim_addr;
  logic [LW-1:0] s_victim_wdata;
  logic          s_victim_write, s_victim_flush, s_mem_req;
  logic [AW-1:0] s_mem_addr;
  logic          s_resp_valid, s_resp_fv;
  logic [LW-1:0] s_resp_data;
  logic [1:0]    s_hit_cnt, s_miss_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  victim_refill_ctrl #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_in), .miss_req_i(miss_req), .miss_addr_i(miss_addr),
    .evict_valid_i(evict_valid), .evict_addr_i(evict_addr), .evict_data_i(evict_data),
    .victim_addr_o(victim_addr), .victim_data_o(victim_wdata), .victim_write_o(victim_write),
    .victim_flush_o(victim_flush), .victim_hit_i(vc_hit), .victim_data_i(vc_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_from_victim_o(resp_fv),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  victim_refill_ctrl #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush_i(1'b0), .miss_req_i(s_miss_req), .miss_addr_i(28'h0000055),
    .evict_valid_i(1'b0), .evict_addr_i(28'h0), .evict_data_i(128'h0),
    .victim_addr_o(s_victim_addr), .victim_data_o(s_victim_wdata), .victim_write_o(s_victim_write),
    .victim_flush_o(s_victim_flush), .victim_hit_i(1'b1), .victim_data_i({16{8'h5A}}),
    .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr), .mem_ack_i(1'b0), .mem_data_i(128'h0),
    .resp_valid_o(s_resp_valid), .resp_data_o(s_resp_data), .resp_from_victim_o(s_resp_fv),
    .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt)
  );

  // Victim cache model: 4 entries, FIFO replacement, combinational lookup
  logic          vc_valid [4];
  logic [AW-1:0] vc_addr  [4];
  logic [LW-1:0] vc_data  [4];
  logic [1:0]    vc_ptr;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [LW-1:0] pre_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        vc_valid[i] <= 1'b0; vc_addr[i] <= '0; vc_data[i] <= '0;
      end
      vc_ptr <= 2'd0;
    end else if (victim_flush) begin
      for (int i = 0; i < 4; i++) vc_valid[i] <= 1'b0;
      vc_ptr <= 2'd0;
    end else if (victim_write || pre_we) begin
      vc_valid[vc_ptr] <= 1'b1;
      vc_addr[vc_ptr]  <= victim_write ? victim_addr : pre_addr;
      vc_data[vc_ptr]  <= victim_write ? victim_wdata : pre_data;
      vc_ptr           <= vc_ptr + 2'd1;
    end
  end

  always_comb begin
    vc_hit   = 1'b0;
    vc_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (vc_valid[i] && vc_addr[i] == victim_addr) begin
        vc_hit   = 1'b1;
        vc_rdata = vc_data[i];
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic preload(input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Issues one miss and plays the memory side; latency counts the LOOKUP cycle as 1.
  task automatic run_miss(input logic [AW-1:0] addr, input logic ev, input logic [AW-1:0] eaddr,
                          input logic [LW-1:0] edata, input int ack_after, input logic [LW-1:0] mdata,
                          input int flush_at, output int lat, output logic [LW-1:0] rdata,
                          output logic rfv, output int mcyc, output int mbad, output int wcnt,
                          output logic [AW-1:0] waddr, output logic [LW-1:0] wdata);
    logic done;
    done = 1'b0; lat = 0; rdata = '0; rfv = 1'b0; mcyc = 0; mbad = 0; wcnt = 0; waddr = '0; wdata = '0;
    @(negedge clk);
    miss_req = 1'b1; miss_addr = addr; evict_valid = ev; evict_addr = eaddr; evict_data = edata;
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge clk);
      mem_ack = 1'b0; flush_in = 1'b0;
      if (mem_req) begin
        mcyc++;
        if (mem_addr !== addr) mbad++;
        if (mcyc == flush_at) flush_in = 1'b1;
        if (mcyc == ack_after) begin mem_ack = 1'b1; mem_data = mdata; end
      end
      if (victim_write) begin wcnt++; waddr = victim_addr; wdata = victim_wdata; end
      if (resp_valid) begin
        lat = n; rdata = resp_data; rfv = resp_fv; done = 1'b1;
        miss_req = 1'b0; evict_valid = 1'b0;
      end
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL miss_timeout addr=%h no resp_valid in 100 cycles", addr); else pass_cnt++;
  endtask

  int lat, mcyc, mbad, wcnt;
  logic [LW-1:0] rdata, wdata;
  logic rfv;
  logic [AW-1:0] waddr;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if ({mem_req, resp_valid, victim_write, victim_flush} !== 4'b0) $display("FAIL reset_strobes got=%b exp=0000", {mem_req, resp_valid, victim_write, victim_flush}); else pass_cnt++;
    total_cnt++; if (victim_addr !== '0 || victim_wdata !== '0) $display("FAIL reset_victim_port addr=%h data=%h exp=0", victim_addr, victim_wdata); else pass_cnt++;
    total_cnt++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || resp_data !== '0) $display("FAIL reset_regs hit=%0d miss=%0d data=%h exp=0", hit_cnt, miss_cnt, resp_data); else pass_cnt++;
  endtask

  task automatic test_hit_no_evict();
    preload(28'h0000123, {16{8'hA5}});
    run_miss(28'h0000123, 1'b0, '0, '0, 0, '0, 0, lat, rdata, rfv, mcyc, mbad, wcnt, waddr, wdata);
    total_cnt++; if (lat !== 2) $display("FAIL hit_latency got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++; if (rdata !== {16{8'hA5}} || rfv !== 1'b1) $display("FAIL hit_resp data=%h fv=%b exp=a5..a5 fv=1", rdata, rfv); else pass_cnt++;
    total_cnt++; if (mcyc !== 0 || wcnt !== 0) $display("FAIL hit_side_effects mem_cycles=%0d writes=%0d exp=0,0", mcyc, wcnt); else pass_cnt++;
    total_cnt++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd0) $display("FAIL hit_counts hit=%0d miss=%0d exp=1,0", hit_cnt, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_mem_evict();
    run_miss(28'h0000456, 1'b1, 28'h0000789, {16{8'h11}}, 4, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0,
             lat, rdata, rfv, mcyc, mbad, wcnt, waddr, wdata);
    total_cnt++; if (mcyc !== 4 || mbad !== 0) $display("FAIL mem_req_hold cycles=%0d bad_addr=%0d exp=4,0", mcyc, mbad); else pass_cnt++;
    total_cnt++; if (wcnt !== 1 || waddr !== 28'h0000789 || wdata !== {16{8'h11}}) $display("FAIL mem_evict_write n=%0d addr=%h data=%h exp=1,0000789,11..11", wcnt, waddr, wdata); else pass_cnt++;
    total_cnt++; if (rdata !== 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D || rfv !== 1'b0) $display("FAIL mem_resp data=%h fv=%b exp=deadbeef.. fv=0", rdata, rfv); else pass_cnt++;
    total_cnt++; if (lat !== 7) $display("FAIL mem_latency got=%0d exp=7", lat); else pass_cnt++;
    total_cnt++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) $display("FAIL mem_counts hit=%0d miss=%0d exp=1,1", hit_cnt, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_hit_evict_full();
    preload(28'h0000AAA, {16{8'hC3}});
    preload(28'h0000BBB, {16{8'h3C}});
    run_miss(28'h0000123, 1'b1, 28'h0000CCC, {16{8'h77}}, 0, '0, 0, lat, rdata, rfv, mcyc, mbad, wcnt, waddr, wdata);
    total_cnt++; if (rdata !== {16{8'hA5}} || rfv !== 1'b1) $display("FAIL full_hit_data data=%h fv=%b exp=a5..a5 fv=1", rdata, rfv); else pass_cnt++;
    total_cnt++; if (lat !== 3 || wcnt !== 1 || waddr !== 28'h0000CCC) $display("FAIL full_hit_evict lat=%0d writes=%0d addr=%h exp=3,1,0000ccc", lat, wcnt, waddr); else pass_cnt++;
    run_miss(28'h0000CCC, 1'b0, '0, '0, 0, '0, 0, lat, rdata, rfv, mcyc, mbad, wcnt, waddr, wdata);
    total_cnt++; if (rdata !== {16{8'h77}} || rfv !== 1'b1 || lat !== 2) $display("FAIL evicted_probe data=%h fv=%b lat=%0d exp=77..77,1,2", rdata, rfv, lat); else pass_cnt++;
    total_cnt++; if (hit_cnt !== 16'd3) $display("FAIL full_hit_count got=%0d exp=3", hit_cnt); else pass_cnt++;
  endtask

  task automatic test_flush_mem();
    int pulses, first;
    run_miss(28'h0000DDD, 1'b0, '0, '0, 3, {8{16'hBEEF}}, 2, lat, rdata, rfv, mcyc, mbad, wcnt, waddr, wdata);
    total_cnt++; if (lat !== 5 || rdata !== {8{16'hBEEF}} || rfv !== 1'b0) $display("FAIL flush_mem_resp lat=%0d data=%h fv=%b exp=5,beef..,0", lat, rdata, rfv); else pass_cnt++;
    pulses = 0; first = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (victim_flush) begin pulses++; if (first == 0) first = k; end
    end
    total_cnt++; if (pulses !== 1 || first > 2 || first < 1) $display("FAIL flush_pending_pulse pulses=%0d first_idle_cycle=%0d exp=1,<=2", pulses, first); else pass_cnt++;
    total_cnt++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) $display("FAIL flush_counts hit=%0d miss=%0d exp=0,0", hit_cnt, miss_cnt); else pass_cnt++;
    run_miss(28'h0000CCC, 1'b0, '0, '0, 1, {16{8'h99}}, 0, lat, rdata, rfv, mcyc, mbad, wcnt, waddr, wdata);
    total_cnt++; if (rfv !== 1'b0 || mcyc !== 1 || lat !== 3 || miss_cnt !== 16'd1) $display("FAIL post_flush_probe fv=%b mem_cycles=%0d lat=%0d miss=%0d exp=0,1,3,1", rfv, mcyc, lat, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_flush_idle_ignores_miss();
    int bad;
    @(negedge clk); flush_in = 1'b1; miss_req = 1'b1; miss_addr = 28'h0000321;
    @(negedge clk); flush_in = 1'b0; miss_req = 1'b0;
    total_cnt++; if (victim_flush !== 1'b1 || victim_addr !== '0) $display("FAIL idle_flush pulse=%b vaddr=%h exp=1,0", victim_flush, victim_addr); else pass_cnt++;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_req || resp_valid || victim_addr !== '0) bad++;
    end
    total_cnt++; if (bad !== 0 || miss_cnt !== 16'd0) $display("FAIL idle_flush_miss_ignored activity=%0d miss=%0d exp=0,0", bad, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int bad;
    @(negedge clk); miss_req = 1'b1; miss_addr = 28'h0000EEE; evict_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL pre_reset_mem_req got=%b exp=1", mem_req); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if ({mem_req, resp_valid} !== 2'b00 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) $display("FAIL async_reset req=%b resp=%b hit=%0d miss=%0d exp=0", mem_req, resp_valid, hit_cnt, miss_cnt); else pass_cnt++;
    miss_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); mem_ack = 1'b1; mem_data = {16{8'hEE}};
    @(negedge clk); mem_ack = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_req) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL late_ack_ignored activity=%0d exp=0", bad); else pass_cnt++;
    run_miss(28'h0000123, 1'b0, '0, '0, 2, {16{8'h42}}, 0, lat, rdata, rfv, mcyc, mbad, wcnt, waddr, wdata);
    total_cnt++; if (lat !== 4 || rdata !== {16{8'h42}} || miss_cnt !== 16'd1) $display("FAIL post_reset_miss lat=%0d data=%h miss=%0d exp=4,42..42,1", lat, rdata, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    logic seen;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); s_miss_req = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        if (s_resp_valid) begin seen = 1'b1; s_miss_req = 1'b0; end
      end
      s_miss_req = 1'b0;
      exp_cnt = (i > 3) ? 3 : i;
      total_cnt++; if (!seen || int'(s_hit_cnt) !== exp_cnt) $display("FAIL sat_hit_cnt txn=%0d resp=%b got=%0d exp=%0d", i, seen, s_hit_cnt, exp_cnt); else pass_cnt++;
    end
    total_cnt++; if (s_miss_cnt !== 2'd0 || s_resp_fv !== 1'b1 || s_resp_data !== {16{8'h5A}}) $display("FAIL sat_misc miss=%0d fv=%b data=%h exp=0,1,5a..5a", s_miss_cnt, s_resp_fv, s_resp_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_hit_no_evict();
    test_mem_evict();
    test_hit_evict_full();
    test_flush_mem();
    test_flush_idle_ignores_miss();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/victim_refill_ctrl.md
Name: victim_refill_ctrl

Overview:
- Dcache-side initiator for the 4-entry victim cache.
- On a dcache miss it probes the victim cache and sources the refill line either from the victim cache (hit) or from memory (miss).
- It then pushes the line evicted by the dcache into the victim cache and returns the refill line to the dcache.
- It owns the victim cache's single shared address port, its write strobe and its flush.

Parameters:
LINE_W, 128, cache line width in bits (matches DCACHE_LINE_WIDTH)
ADDR_W, 28, line address width in bits (matches VICTIM_ADDR_BITS)
CNT_W, 16, width of the hit/miss statistic counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush_i  in  1  flush request from dcache
miss_req_i  in  1  dcache miss request, held until resp_valid_o
miss_addr_i  in  ADDR_W  line address of the missing line
evict_valid_i  in  1  dcache has a valid line to evict for this miss
evict_addr_i  in  ADDR_W  line address of the evicted line
evict_data_i  in  LINE_W  data of the evicted line
victim_addr_o  out  ADDR_W  address to victim cache (lookup and write share this port)
victim_data_o  out  LINE_W  write data to victim cache
victim_write_o  out  1  write strobe to victim cache
victim_flush_o  out  1  flush to victim cache
victim_hit_i  in  1  victim cache combinational hit
victim_data_i  in  LINE_W  victim cache combinational hit data
mem_req_o  out  1  memory line read request
mem_addr_o  out  ADDR_W  memory line address
mem_ack_i  in  1  memory data valid, one-cycle pulse
mem_data_i  in  LINE_W  memory line data
resp_valid_o  out  1  refill line valid, one-cycle pulse
resp_data_o  out  LINE_W  refill line
resp_from_victim_o  out  1  1 = line came from victim cache
hit_cnt_o  out  CNT_W  saturating victim hit count
miss_cnt_o  out  CNT_W  saturating victim miss count

Behaviour:
- Reset (rst low, async): state IDLE, all outputs 0, internal registers and counters cleared.
- FSM states: IDLE, LOOKUP, MEM, WRVIC, RESP.
- IDLE:
  - flush_i high: pulse victim_flush_o for one cycle, clear both counters, stay in IDLE; any miss_req_i that cycle is ignored.
  - Else if miss_req_i: latch miss_addr, evict_valid, evict_addr and evict_data; go to LOOKUP.
- LOOKUP (exactly 1 cycle): victim_addr_o = latched miss_addr, victim_write_o = 0.
  - victim_hit_i = 1: capture victim_data_i into the refill register, set from_victim, increment hit_cnt; go to WRVIC if evict_valid, else RESP.
  - victim_hit_i = 0: increment miss_cnt; go to MEM.
- MEM:
  - mem_req_o = 1 and mem_addr_o = miss_addr, held every cycle until mem_ack_i. No timeout.
  - On the mem_ack_i cycle: capture mem_data_i, clear from_victim, deassert mem_req_o from the next cycle; go to WRVIC if evict_valid, else RESP.
  - mem_ack_i outside MEM is ignored.
- WRVIC (exactly 1 cycle): victim_write_o = 1, victim_addr_o = evict_addr, victim_data_o = evict_data; go to RESP.
  - Victim cache replacement may overwrite the entry just hit. This is legal: the data was already captured.
- RESP (exactly 1 cycle): resp_valid_o = 1 with resp_data_o and resp_from_victim_o from the registers; go to IDLE.
  - A new miss_req_i is accepted no earlier than the next IDLE cycle.
- Latency from the miss_req_i accept edge to resp_valid_o:
  - Victim hit, no evict: 2 cycles. Victim hit with evict: 3 cycles.
  - Memory path: 2 + (cycles in MEM) + (1 if evict).
- Flush outside IDLE: latched as pending and serviced on the first IDLE cycle, before any new miss; the in-flight transaction completes normally.
- Counters: saturate at all-ones; no wrap.
- Idle output values:
  - victim_addr_o = 0 in IDLE, RESP and MEM.
  - victim_data_o = 0 except in WRVIC.
  - resp_data_o holds its last value; it is valid only while resp_valid_o = 1.
- Evict address equal to miss address is a dcache protocol error; behaviour undefined, not checked.

Test Plan:
1. Victim hit, no evict: preload victim entry addr 0x0000123 with data 0xA5..A5; miss_req addr 0x0000123, evict_valid = 0 -> resp_valid 2 cycles after accept, data 0xA5..A5, from_victim = 1, hit_cnt = 1, no mem_req.
2. Victim miss, memory path with evict: miss addr 0x0000456, evict addr 0x0000789 with data 0x11..11, mem_ack 4 cycles after mem_req -> mem_addr = 0x0000456 held 4 cycles; victim_write pulses once with addr 0x0000789 and data 0x11..11; resp data = mem_data, from_victim = 0, miss_cnt = 1.
3. Hit plus evict into a full victim cache: 4 valid entries, hit on the entry next to be replaced, with evict -> resp carries the pre-overwrite hit data; a later probe of the evicted addr hits.
4. Flush during MEM: flush_i pulsed while waiting on mem_ack -> transaction completes, resp_valid, then victim_flush_o pulses in the following IDLE cycle; counters = 0; a subsequent probe of the earlier address misses.
5. Async reset mid-MEM: rst low while mem_req_o = 1 -> mem_req_o, resp_valid_o and counters all 0 immediately; FSM in IDLE after release; a late mem_ack_i is ignored.
6. Saturation with CNT_W = 2: 5 victim hits -> hit_cnt_o = 3.
